// File: rtl/fan_tach_monitor.sv
// Multi-channel fan tachometer monitor.
// Each TACH input is synchronised, glitch-filtered and its falling edges are
// counted over a fixed gate window. At the end of every window the pulse
// count is scaled to RPM (saturating) and per-channel stall/saturation flags
// are refreshed, all qualified by a one-cycle rpm_valid strobe.
module fan_tach_monitor #(
  parameter int N_CH        = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_MS     = 1000,
  parameter int PPR         = 2,
  parameter int FILT_CYC    = 16,
  parameter int RPM_W       = 16,
  parameter int STALL_GATES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [N_CH-1:0]         tach,
  output logic [N_CH*RPM_W-1:0]   rpm,
  output logic                    rpm_valid,
  output logic [N_CH-1:0]         stall,
  output logic [N_CH-1:0]         sat
);

  localparam int GATE_CYC = CLK_HZ / 1000 * GATE_MS;
  localparam int RPM_DEN  = (PPR * GATE_MS > 0) ? PPR * GATE_MS : 1;
  localparam int RPM_MUL  = 60000 / RPM_DEN;

  localparam int TW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int FW = $clog2(FILT_CYC + 1);
  localparam int ZW = $clog2(STALL_GATES + 1);
  localparam int MW = $clog2(RPM_MUL + 1);
  localparam int PW = 16 + MW;
  localparam int XW = (PW > RPM_W) ? PW : RPM_W;

  localparam logic [TW-1:0] TMR_LAST = TW'(GATE_CYC - 1);
  localparam logic [FW-1:0] RUN_LAST = FW'(FILT_CYC - 1);
  localparam logic [ZW-1:0] ZC_MAX   = ZW'(STALL_GATES);
  localparam logic [XW-1:0] RPM_MAX  = XW'({RPM_W{1'b1}});
  localparam logic [XW-1:0] MUL_X    = XW'(RPM_MUL);

  // Elaboration-time parameter sanity checks
  if (CLK_HZ % 1000 != 0) begin : g_chk_clk
    $error("fan_tach_monitor: CLK_HZ must be a multiple of 1000");
  end
  if (PPR * GATE_MS <= 0 || 60000 % RPM_DEN != 0 || RPM_MUL < 1) begin : g_chk_mul
    $error("fan_tach_monitor: 60000/(PPR*GATE_MS) must be an integer >= 1");
  end
  if (FILT_CYC < 1 || STALL_GATES < 1 || N_CH < 1 || GATE_CYC < 1) begin : g_chk_rng
    $error("fan_tach_monitor: FILT_CYC, STALL_GATES, N_CH and gate length must be >= 1");
  end

  logic [N_CH-1:0]  sync1_q, sync2_q;
  logic [N_CH-1:0]  filt_q, filt_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [FW-1:0]    run_q [N_CH];
  logic [FW-1:0]    run_d [N_CH];

  logic [TW-1:0]    tmr_q, tmr_d;
  logic             term;
  logic             valid_q;

  logic [15:0]      cnt_q [N_CH];
  logic [15:0]      cnt_d [N_CH];
  logic [15:0]      pcnt  [N_CH];
  logic [XW-1:0]    prod  [N_CH];
  logic [N_CH-1:0]  clamp;
  logic [ZW-1:0]    zc_q  [N_CH];
  logic [ZW-1:0]    zc_d  [N_CH];
  logic [RPM_W-1:0] rpm_q [N_CH];
  logic [RPM_W-1:0] rpm_d [N_CH];
  logic [N_CH-1:0]  stall_q, stall_d;
  logic [N_CH-1:0]  sat_q, sat_d;

  // Glitch filter: flip only after FILT_CYC consecutive disagreeing samples
  always_comb begin
    filt_d = filt_q;
    fall_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      run_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (run_q[i] == RUN_LAST) begin
          filt_d[i] = ~filt_q[i];
        end else begin
          run_d[i] = run_q[i] + FW'(1);
        end
      end
      fall_d[i] = filt_q[i] & ~filt_d[i];
    end
  end

  // Synchroniser, filter state and edge pulse registers (idle high)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '1;
      sync2_q <= '1;
      filt_q  <= '1;
      fall_q  <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        run_q[i] <= '0;
      end
    end else begin
      sync1_q <= tach;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        run_q[i] <= run_d[i];
      end
    end
  end

  assign term = en & (tmr_q == TMR_LAST);

  // Gate timer, pulse counters and end-of-window result computation.
  // An edge landing on the terminal cycle is folded into the closing
  // window's total and the counter still restarts from zero.
  always_comb begin
    tmr_d = (!en || term) ? '0 : tmr_q + TW'(1);
    for (int unsigned i = 0; i < N_CH; i++) begin
      pcnt[i]  = (fall_q[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
      prod[i]  = XW'(pcnt[i]) * MUL_X;
      clamp[i] = prod[i] > RPM_MAX;
      cnt_d[i] = (!en || term) ? '0 : pcnt[i];
      rpm_d[i] = rpm_q[i];
      zc_d[i]  = zc_q[i];
      sat_d[i]   = sat_q[i];
      stall_d[i] = stall_q[i];
      if (term) begin
        rpm_d[i] = clamp[i] ? '1 : prod[i][RPM_W-1:0];
        sat_d[i] = clamp[i] | (pcnt[i] == 16'hFFFF);
        if (pcnt[i] == 16'd0) begin
          zc_d[i]    = (zc_q[i] == ZC_MAX) ? zc_q[i] : zc_q[i] + ZW'(1);
          stall_d[i] = (zc_d[i] == ZC_MAX);
        end else begin
          zc_d[i]    = '0;
          stall_d[i] = 1'b0;
        end
      end
    end
  end

  // Measurement state and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmr_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      sat_q   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        zc_q[i]  <= '0;
        rpm_q[i] <= '0;
      end
    end else begin
      tmr_q   <= tmr_d;
      valid_q <= term;
      stall_q <= stall_d;
      sat_q   <= sat_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        zc_q[i]  <= zc_d[i];
        rpm_q[i] <= rpm_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign rpm[g*RPM_W +: RPM_W] = rpm_q[g];
  end

  assign rpm_valid = valid_q;
  assign stall     = stall_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Directed bench for fan_tach_monitor: 2 channels, 1000-cycle window,
// RPM_MUL = 3000, 4-cycle filter, stall after 2 empty windows.
// A filtered edge whose first low sample is at posedge k of a window is
// counted at posedge k+6; windows start at the posedge following the
// cycle in which rpm_valid is high.
module tb_fan_tach_monitor;

  localparam int BIG = 1_000_000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  tach;
  logic [31:0] rpm;
  logic        rpm_valid;
  logic [1:0]  stall;
  logic [1:0]  sat;

  int checks   = 0;
  int failures = 0;

  // Per-channel waveform generator: mode 0 idle high, 1 square, 2 glitch
  int gmode [2];
  int gper  [2];
  int glo   [2];
  int gleft [2];
  int gph   [2];
  bit gact  [2];

  fan_tach_monitor #(
    .N_CH(2), .CLK_HZ(100_000), .GATE_MS(10), .PPR(2),
    .FILT_CYC(4), .RPM_W(16), .STALL_GATES(2)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .tach(tach),
    .rpm(rpm), .rpm_valid(rpm_valid), .stall(stall), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic gen_cfg(input int ch, input int mode, input int per,
                         input int lo, input int left, input int ph0);
    gmode[ch] = mode;
    gper[ch]  = per;
    glo[ch]   = lo;
    gleft[ch] = left;
    gph[ch]   = ph0;
    gact[ch]  = 1'b0;
  endtask

  // Drive tach for the next posedge, then advance to the following negedge
  task automatic step();
    for (int ch = 0; ch < 2; ch++) begin
      bit v;
      v = 1'b1;
      case (gmode[ch])
        1: begin
          if (gph[ch] == 0) begin
            gact[ch] = (gleft[ch] > 0);
            if (gact[ch]) gleft[ch]--;
          end
          v = !(gact[ch] && gph[ch] < glo[ch]);
          gph[ch] = (gph[ch] + 1) % gper[ch];
        end
        2: begin
          v = !(gph[ch] < 4 || (gph[ch] >= 100 && gph[ch] < 103) ||
                (gph[ch] >= 200 && gph[ch] < 203) || (gph[ch] >= 300 && gph[ch] < 303));
          gph[ch] = (gph[ch] + 1) % 500;
        end
        default: v = 1'b1;
      endcase
      tach[ch] = v;
    end
    @(negedge clk);
  endtask

  // Steps until rpm_valid is seen; n = steps taken, or -1 on timeout
  task automatic wait_valid(input int limit, output int n);
    int k;
    n = -1;
    k = 0;
    while (n < 0 && k < limit) begin
      step();
      k++;
      if (rpm_valid === 1'b1) n = k;
    end
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0;
    en   = 1'b0;
    tach = 2'b11;
    gen_cfg(0, 0, 1, 0, 0, 0);
    gen_cfg(1, 0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if ({rpm, rpm_valid, stall, sat} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rpm=%h valid=%b stall=%b sat=%b expected all zero",
               rpm, rpm_valid, stall, sat);
    end
    rstn = 1'b1;
    en   = 1'b1;
    // rpm_valid is high in the 1001st cycle after release
    wait_valid(1100, n);
    checks++;
    if (n !== 1000) begin
      failures++;
      $display("FAIL first_valid_latency: got %0d expected 1000", n);
    end
    checks++;
    if (rpm !== 32'd0 || stall !== 2'b00 || sat !== 2'b00) begin
      failures++;
      $display("FAIL first_window: got rpm=%h stall=%b sat=%b expected 0/00/00", rpm, stall, sat);
    end
  endtask

  task automatic test_clean();
    int n;
    gen_cfg(0, 1, 200, 100, BIG, 0);
    gen_cfg(1, 0, 1, 0, 0, 0);
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, n);
      checks++;
      if (n !== 1000) begin
        failures++;
        $display("FAIL clean_period[%0d]: got %0d expected 1000", w, n);
      end
      checks++;
      if (rpm[15:0] !== 16'd15000 || rpm[31:16] !== 16'd0 || sat !== 2'b00) begin
        failures++;
        $display("FAIL clean_rpm[%0d]: got rpm0=%0d rpm1=%0d sat=%b expected 15000 0 00",
                 w, rpm[15:0], rpm[31:16], sat);
      end
      checks++;
      if (stall !== 2'b10) begin
        failures++;
        $display("FAIL clean_stall[%0d]: got %b expected 10", w, stall);
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    gen_cfg(0, 2, 500, 0, 0, 0);
    for (int w = 0; w < 2; w++) begin
      wait_valid(1100, n);
      checks++;
      if (n !== 1000 || rpm[15:0] !== 16'd6000 || sat !== 2'b00) begin
        failures++;
        $display("FAIL glitch_rpm[%0d]: got n=%0d rpm0=%0d sat=%b expected 1000 6000 00",
                 w, n, rpm[15:0], sat);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    gen_cfg(0, 1, 200, 100, BIG, 0);
    gen_cfg(1, 1, 40, 20, 22, 0);
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[31:16] !== 16'd65535 || sat !== 2'b10) begin
      failures++;
      $display("FAIL sat_window: got n=%0d rpm1=%0d sat=%b expected 1000 65535 10",
               n, rpm[31:16], sat);
    end
    checks++;
    if (rpm[15:0] !== 16'd15000 || stall !== 2'b00) begin
      failures++;
      $display("FAIL sat_other: got rpm0=%0d stall=%b expected 15000 00", rpm[15:0], stall);
    end
    gen_cfg(1, 1, 200, 100, 5, 0);
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[31:16] !== 16'd15000 || sat !== 2'b00) begin
      failures++;
      $display("FAIL sat_recover: got n=%0d rpm1=%0d sat=%b expected 1000 15000 00",
               n, rpm[31:16], sat);
    end
  endtask

  task automatic test_stall();
    int n;
    gen_cfg(0, 0, 1, 0, 0, 0);
    gen_cfg(1, 0, 1, 0, 0, 0);
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[15:0] !== 16'd0 || stall !== 2'b00) begin
      failures++;
      $display("FAIL stall_first_empty: got n=%0d rpm0=%0d stall=%b expected 1000 0 00",
               n, rpm[15:0], stall);
    end
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[15:0] !== 16'd0 || stall !== 2'b11) begin
      failures++;
      $display("FAIL stall_second_empty: got n=%0d rpm0=%0d stall=%b expected 1000 0 11",
               n, rpm[15:0], stall);
    end
    gen_cfg(0, 1, 200, 100, BIG, 0);
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[15:0] !== 16'd15000 || stall !== 2'b10) begin
      failures++;
      $display("FAIL stall_resume: got n=%0d rpm0=%0d stall=%b expected 1000 15000 10",
               n, rpm[15:0], stall);
    end
  endtask

  task automatic test_boundary();
    int n;
    // ch1 edge counted on the terminal posedge (1000), ch0 on posedge 1001
    gen_cfg(0, 1, 1000, 100, 1, 6);
    gen_cfg(1, 1, 1000, 100, 1, 7);
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[15:0] !== 16'd0 || rpm[31:16] !== 16'd3000 || stall !== 2'b00) begin
      failures++;
      $display("FAIL boundary_closing: got n=%0d rpm0=%0d rpm1=%0d stall=%b expected 1000 0 3000 00",
               n, rpm[15:0], rpm[31:16], stall);
    end
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[15:0] !== 16'd3000 || rpm[31:16] !== 16'd0 || stall !== 2'b00) begin
      failures++;
      $display("FAIL boundary_next: got n=%0d rpm0=%0d rpm1=%0d stall=%b expected 1000 3000 0 00",
               n, rpm[15:0], rpm[31:16], stall);
    end
  endtask

  task automatic test_reset_enable();
    int n;
    int vcnt;
    gen_cfg(0, 0, 1, 0, 0, 0);
    gen_cfg(1, 0, 1, 0, 0, 0);
    repeat (300) step();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({rpm, rpm_valid, stall, sat} !== 37'd0) begin
      failures++;
      $display("FAIL async_reset: got rpm=%h valid=%b stall=%b sat=%b expected all zero",
               rpm, rpm_valid, stall, sat);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    gen_cfg(0, 1, 200, 100, BIG, 0);
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[15:0] !== 16'd15000) begin
      failures++;
      $display("FAIL release_latency: got n=%0d rpm0=%0d expected 1000 15000", n, rpm[15:0]);
    end
    repeat (300) step();
    en = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (rpm_valid !== 1'b0) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin
      failures++;
      $display("FAIL en_low_no_valid: got %0d strobes expected 0", vcnt);
    end
    checks++;
    if (rpm[15:0] !== 16'd15000) begin
      failures++;
      $display("FAIL en_low_hold: got rpm0=%0d expected 15000", rpm[15:0]);
    end
    en = 1'b1;
    wait_valid(1100, n);
    checks++;
    if (n !== 1000 || rpm[15:0] !== 16'd15000) begin
      failures++;
      $display("FAIL reenable_latency: got n=%0d rpm0=%0d expected 1000 15000", n, rpm[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_saturation();
    test_stall();
    test_boundary();
    test_reset_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fan_tach_monitor.md
Name: fan_tach_monitor

Overview:
Multi-channel fan tachometer monitor. It measures RPM for N_CH fans over a parametrised gate window and supports any pulses-per-revolution setting. Each channel has a synchroniser and glitch filter, saturating arithmetic and stall detection. It sits between the fan TACH pins and the fan-control/telemetry logic, and supersedes the single-channel fixed-1-s counter.

Parameters:
N_CH, 4, number of tach channels
CLK_HZ, 50_000_000, clk frequency in Hz
GATE_MS, 1000, measurement window in ms; GATE_CYC = CLK_HZ/1000*GATE_MS (exact, elaboration error if CLK_HZ%1000 != 0)
PPR, 2, tach pulses per revolution; RPM_MUL = 60000/(PPR*GATE_MS), elaboration error if not an exact integer >= 1
FILT_CYC, 16, consecutive stable cycles required to accept a tach level change (>= 1)
RPM_W, 16, width of each RPM result
STALL_GATES, 2, consecutive zero-pulse windows before stall asserts (>= 1)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  measurement enable
tach  in  N_CH  raw open-drain TACH inputs (asynchronous, idle high)
rpm  out  N_CH*RPM_W  channel i at [i*RPM_W +: RPM_W]
rpm_valid  out  1  one-cycle strobe when all rpm fields update
stall  out  N_CH  per-channel stall flag
sat  out  N_CH  per-channel saturation flag for the last window

Behaviour:
- Reset: clk/rstn per decision (rstn asynchronous, active-low, clock clk). All outputs reset to 0: rpm, rpm_valid, stall, sat. Synchroniser and filter state reset to 1 (idle high). Gate timer and pulse counters reset to 0.
- Sync: 2-FF synchroniser per channel.
- Filter: per-channel run counter. The filtered level flips only after the synced input has differed from it for FILT_CYC consecutive cycles. Any return to the filtered level resets the run counter.
- Edge: count = filtered 1->0 transition, one cycle wide. Latency from raw tach fall to counted edge = 2 + FILT_CYC cycles.
- Pulse counter: 16 bits per channel, saturates at 0xFFFF and does not wrap.
- Gate timer: counts 0..GATE_CYC-1 while en=1. Terminal cycle = count GATE_CYC-1; the timer then returns to 0. Window length is exactly GATE_CYC cycles.
- Terminal cycle, per channel:
  - P = pulse_count + edge_this_cycle, using saturating add.
  - Register rpm = min(P*RPM_MUL, 2^RPM_W-1). The product is computed at full width (16 + clog2(RPM_MUL+1) bits) before the clamp.
  - sat = 1 if the clamp applied or the pulse counter saturated, else 0.
  - pulse_count clears to 0. An edge on the terminal cycle is counted in the closing window, never in both windows.
- rpm_valid: high for exactly one cycle, the cycle after the terminal cycle, coincident with the new rpm/sat/stall values. It stays low at all other times.
- Stall: per-channel zero-window counter, saturating at STALL_GATES.
  - P==0 increments it; stall asserts at the update where the count reaches STALL_GATES.
  - P!=0 clears the counter and stall at that same update.
  - stall changes only on rpm_valid cycles.
- en=0: gate timer and pulse counters are held at 0, and no rpm_valid is generated. rpm, stall and sat hold their last values. Sync and filter keep running. On en 0->1, a fresh full window starts at timer 0.
- Reset mid-window: everything returns to reset values immediately. After release with en=1, the first rpm_valid occurs GATE_CYC+1 cycles after the first active clock edge.
- Channels are fully independent. Simultaneous edges on all channels in the same cycle are all counted.

Test Plan:
Test config for all scenarios: N_CH=2, CLK_HZ=100_000, GATE_MS=10, PPR=2, FILT_CYC=4, STALL_GATES=2 (GATE_CYC=1000, RPM_MUL=3000).
1. Clean counting: ch0 square wave with 200-cycle period (100 low / 100 high), ch1 idle high. -> rpm_valid once per 1000 cycles; rpm0=15000, rpm1=0; sat=0.
2. Glitch filter: ch0 gets 3-cycle low glitches plus two 4-cycle lows per window. -> rpm0=6000; the glitches are never counted.
3. Saturation: ch1 gets 22 clean pulses in one window. -> rpm1=65535, sat[1]=1. Next window with 5 pulses -> rpm1=15000, sat[1]=0.
4. Stall: ch0 running, then held high. -> first empty window rpm0=0, stall[0]=0; second empty window stall[0]=1. Resume pulses -> stall[0]=0 on the first non-empty window.
5. Boundary edge: place a filtered falling edge exactly on the terminal cycle. -> it is counted once in the closing window; the next window starts from 0.
6. Reset/enable: assert rstn mid-window -> all outputs 0 asynchronously; first rpm_valid 1001 cycles after release. Drop en for 300 cycles -> no rpm_valid and rpm held; on re-enable, the next rpm_valid comes 1001 cycles later.
